// File: rtl/tlu_trigger_logic.sv
// tlu_trigger_logic: coincidence and trigger generation for the TLU master.
// Builds a trigger condition from per-channel hit validity and relative
// leading edges. The condition is AND, OR, majority or test-pulse-only. It is
// then edge-detected, gated by output readiness, prescaled, and issued as a
// one-cycle trigger. Each trigger also pushes a record into a small FIFO.
//
// Ports (single clock domain CLK40, async active-low RST_N):
//   START                   one-cycle run start: clears IDs, counters, FIFO
//   CONF_*                  static configuration (mode, enables, thresholds)
//   VALID / LE_REL          per-channel hit valid and relative leading edge
//   TEST_PULSE              forces the coincidence condition
//   READY                   per-output ready from the DUT transmitters
//   TRIG_PULSE / TRIG_LE    accepted trigger and its max leading edge
//   TRIG_ID / TIME_STAMP    next trigger ID and run time counter
//   REC_VALID/READY/DATA    record stream {trig_id, time_stamp, hit_mask}
//   SKIP_CNT/PRESC_CNT/LOST_CNT  saturating status counters
// Optional feature macro: TLU_TRIG_HOLDOFF_EN adds CONF_HOLDOFF. After each
// accept, candidates are rejected for CONF_HOLDOFF cycles.
module tlu_trigger_logic #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned N_OUT         = 6,
    parameter int unsigned LE_WIDTH      = 8,
    parameter int unsigned TRIG_ID_WIDTH = 32,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned REC_ASIZE     = 3
) (
    input  logic                               CLK40,
    input  logic                               RST_N,
    input  logic                               START,
    input  logic [1:0]                         CONF_MODE,
    input  logic [N_IN-1:0]                    CONF_EN_INPUT,
    input  logic [4:0]                         CONF_MIN_HITS,
    input  logic [LE_WIDTH-1:0]                CONF_MAX_LE_DISTANCE,
    input  logic [N_OUT-1:0]                   CONF_EN_OUTPUT,
    input  logic [15:0]                        CONF_PRESCALE,
`ifdef TLU_TRIG_HOLDOFF_EN
    input  logic [15:0]                        CONF_HOLDOFF,
`endif
    input  logic [N_IN-1:0]                    VALID,
    input  logic [N_IN*LE_WIDTH-1:0]           LE_REL,
    input  logic                               TEST_PULSE,
    input  logic [N_OUT-1:0]                   READY,
    output logic                               TRIG_PULSE,
    output logic [LE_WIDTH-1:0]                TRIG_LE,
    output logic [TRIG_ID_WIDTH-1:0]           TRIG_ID,
    output logic [63:0]                        TIME_STAMP,
    output logic                               REC_VALID,
    input  logic                               REC_READY,
    output logic [TRIG_ID_WIDTH+64+N_IN-1:0]   REC_DATA,
    output logic [CNT_WIDTH-1:0]               SKIP_CNT,
    output logic [CNT_WIDTH-1:0]               PRESC_CNT,
    output logic [CNT_WIDTH-1:0]               LOST_CNT
);

    localparam int unsigned REC_W = TRIG_ID_WIDTH + 64 + N_IN;
    localparam int unsigned DEPTH = 1 << REC_ASIZE;
    localparam int unsigned PTR_W = REC_ASIZE + 1;

    // Condition evaluation (combinational)
    logic [N_IN-1:0]     p_c;
    logic [4:0]          hits_c;
    logic [LE_WIDTH-1:0] max_le_c, min_le_c;
    logic                le_ok_c, cond_c;

    always_comb begin
        p_c      = VALID & CONF_EN_INPUT;
        hits_c   = '0;
        max_le_c = '0;
        min_le_c = '1;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (p_c[i]) begin
                hits_c = hits_c + 5'(p_c[i]);
                if (LE_REL[i*LE_WIDTH +: LE_WIDTH] > max_le_c) max_le_c = LE_REL[i*LE_WIDTH +: LE_WIDTH];
                if (LE_REL[i*LE_WIDTH +: LE_WIDTH] < min_le_c) min_le_c = LE_REL[i*LE_WIDTH +: LE_WIDTH];
            end
        end
        // With no participants the window check is vacuous; the mode term decides.
        le_ok_c = (p_c == '0) || ((max_le_c - min_le_c) <= CONF_MAX_LE_DISTANCE);
        unique case (CONF_MODE)
            2'd0:    cond_c = (p_c == CONF_EN_INPUT) && (CONF_EN_INPUT != '0) && le_ok_c;
            2'd1:    cond_c = (p_c != '0) && le_ok_c;
            2'd2:    cond_c = (hits_c >= CONF_MIN_HITS) && (CONF_MIN_HITS != '0) && le_ok_c;
            default: cond_c = 1'b0;
        endcase
        cond_c = cond_c | TEST_PULSE;
    end

    // State registers
    logic                     c_q, c_d, cc_q, cc_d;
    logic [N_IN-1:0]          p_q, p_d;
    logic [LE_WIDTH-1:0]      le_q, le_d, trig_le_q, trig_le_d;
    logic                     trig_pulse_q, trig_pulse_d;
    logic [TRIG_ID_WIDTH-1:0] trig_id_q, trig_id_d;
    logic [63:0]              ts_q, ts_d;
    logic [CNT_WIDTH-1:0]     skip_q, skip_d, presc_q, presc_d, lost_q, lost_d;
    logic [15:0]              pcount_q, pcount_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [REC_W-1:0]         mem_q [DEPTH];
`ifdef TLU_TRIG_HOLDOFF_EN
    logic [15:0]              holdoff_q, holdoff_d;
`endif

    logic cand_c, all_ready_c, blocked_c, full_c, empty_c, pop_c, push_c;

    assign cand_c      = c_q & ~cc_q;
    assign all_ready_c = &(READY | ~CONF_EN_OUTPUT);
    assign empty_c     = (wr_ptr_q == rd_ptr_q);
    assign full_c      = (wr_ptr_q[REC_ASIZE] != rd_ptr_q[REC_ASIZE]) &&
                         (wr_ptr_q[REC_ASIZE-1:0] == rd_ptr_q[REC_ASIZE-1:0]);
    assign pop_c       = ~empty_c & REC_READY & ~START;
`ifdef TLU_TRIG_HOLDOFF_EN
    assign blocked_c   = (holdoff_q != 16'd0);
`else
    assign blocked_c   = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        c_d          = cond_c;
        cc_d         = c_q;
        p_d          = p_c;
        le_d         = max_le_c;
        trig_pulse_d = 1'b0;
        trig_le_d    = trig_le_q;
        trig_id_d    = trig_id_q;
        ts_d         = ts_q;
        skip_d       = skip_q;
        presc_d      = presc_q;
        lost_d       = lost_q;
        pcount_d     = pcount_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        push_c       = 1'b0;
`ifdef TLU_TRIG_HOLDOFF_EN
        holdoff_d    = holdoff_q;
`endif
        if (START) begin
            // START overrides any candidate in the same cycle.
            ts_d      = 64'd1;
            trig_id_d = '0;
            skip_d    = '0;
            presc_d   = '0;
            lost_d    = '0;
            pcount_d  = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
`ifdef TLU_TRIG_HOLDOFF_EN
            holdoff_d = '0;
`endif
        end else begin
            ts_d = (ts_q == '1) ? ts_q : ts_q + 64'd1;
`ifdef TLU_TRIG_HOLDOFF_EN
            if (holdoff_q != 16'd0) holdoff_d = holdoff_q - 16'd1;
`endif
            if (cand_c) begin
                if (blocked_c || !all_ready_c) begin
                    skip_d = (skip_q == '1) ? skip_q : skip_q + CNT_WIDTH'(1);
                end else if (pcount_q == CONF_PRESCALE) begin
                    pcount_d     = '0;
                    trig_pulse_d = 1'b1;
                    trig_le_d    = le_q;
                    trig_id_d    = trig_id_q + TRIG_ID_WIDTH'(1);
`ifdef TLU_TRIG_HOLDOFF_EN
                    holdoff_d    = CONF_HOLDOFF;
`endif
                    // A simultaneous pop frees the slot, so a full FIFO can still accept.
                    if (full_c && !pop_c) lost_d = (lost_q == '1) ? lost_q : lost_q + CNT_WIDTH'(1);
                    else                  push_c = 1'b1;
                end else begin
                    pcount_d = pcount_q + 16'd1;
                    presc_d  = (presc_q == '1) ? presc_q : presc_q + CNT_WIDTH'(1);
                end
            end
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            c_q          <= 1'b0;
            cc_q         <= 1'b0;
            p_q          <= '0;
            le_q         <= '0;
            trig_pulse_q <= 1'b0;
            trig_le_q    <= '0;
            trig_id_q    <= '0;
            ts_q         <= '0;
            skip_q       <= '0;
            presc_q      <= '0;
            lost_q       <= '0;
            pcount_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
`ifdef TLU_TRIG_HOLDOFF_EN
            holdoff_q    <= '0;
`endif
        end else begin
            c_q          <= c_d;
            cc_q         <= cc_d;
            p_q          <= p_d;
            le_q         <= le_d;
            trig_pulse_q <= trig_pulse_d;
            trig_le_q    <= trig_le_d;
            trig_id_q    <= trig_id_d;
            ts_q         <= ts_d;
            skip_q       <= skip_d;
            presc_q      <= presc_d;
            lost_q       <= lost_d;
            pcount_q     <= pcount_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
`ifdef TLU_TRIG_HOLDOFF_EN
            holdoff_q    <= holdoff_d;
`endif
        end
    end

    // Record storage; contents are only observed while REC_VALID is high.
    always_ff @(posedge CLK40) begin
        if (push_c) mem_q[wr_ptr_q[REC_ASIZE-1:0]] <= {trig_id_q, ts_q, p_q};
    end

    assign TRIG_PULSE = trig_pulse_q;
    assign TRIG_LE    = trig_le_q;
    assign TRIG_ID    = trig_id_q;
    assign TIME_STAMP = ts_q;
    assign REC_VALID  = ~empty_c;
    assign REC_DATA   = mem_q[rd_ptr_q[REC_ASIZE-1:0]];
    assign SKIP_CNT   = skip_q;
    assign PRESC_CNT  = presc_q;
    assign LOST_CNT   = lost_q;

endmodule

// File: tb/tb_tlu_trigger_logic.sv
// Directed bench for tlu_trigger_logic with default parameters.
module tb_tlu_trigger_logic;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 6;
    localparam int unsigned REC_W = 32 + 64 + 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        conf_mode;
    logic [N_IN-1:0]   conf_en_input;
    logic [4:0]        conf_min_hits;
    logic [7:0]        conf_max_le;
    logic [N_OUT-1:0]  conf_en_output;
    logic [15:0]       conf_prescale;
    logic [15:0]       conf_holdoff;
    logic [N_IN-1:0]   valid;
    logic [31:0]       le_rel;
    logic              test_pulse;
    logic [N_OUT-1:0]  ready;
    logic              trig_pulse;
    logic [7:0]        trig_le;
    logic [31:0]       trig_id;
    logic [63:0]       time_stamp;
    logic              rec_valid;
    logic              rec_ready;
    logic [REC_W-1:0]  rec_data;
    logic [15:0]       skip_cnt, presc_cnt, lost_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_ts;
    logic [63:0] rec_ts;
    int          npulse;
    logic        saw;
    logic [31:0] exp_id;

    always #5 clk = ~clk;

    tlu_trigger_logic dut (
        .CLK40(clk), .RST_N(rst_n), .START(start),
        .CONF_MODE(conf_mode), .CONF_EN_INPUT(conf_en_input),
        .CONF_MIN_HITS(conf_min_hits), .CONF_MAX_LE_DISTANCE(conf_max_le),
        .CONF_EN_OUTPUT(conf_en_output), .CONF_PRESCALE(conf_prescale),
`ifdef TLU_TRIG_HOLDOFF_EN
        .CONF_HOLDOFF(conf_holdoff),
`endif
        .VALID(valid), .LE_REL(le_rel), .TEST_PULSE(test_pulse), .READY(ready),
        .TRIG_PULSE(trig_pulse), .TRIG_LE(trig_le), .TRIG_ID(trig_id),
        .TIME_STAMP(time_stamp), .REC_VALID(rec_valid), .REC_READY(rec_ready),
        .REC_DATA(rec_data), .SKIP_CNT(skip_cnt), .PRESC_CNT(presc_cnt),
        .LOST_CNT(lost_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_ts = exp_ts + 64'd1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ts = 64'd1;
    endtask

    // One test-pulse candidate; reports whether the trigger fired 2 cycles later.
    task automatic cand_tp(output logic fired);
        test_pulse = 1'b1;
        tick();
        test_pulse = 1'b0;
        tick();
        fired = trig_pulse;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; conf_mode = 2'd0; conf_en_input = 4'b0111;
        conf_min_hits = 5'd0; conf_max_le = 8'd4; conf_en_output = 6'h3F;
        conf_prescale = 16'd0; conf_holdoff = 16'd0; valid = '0; le_rel = '0;
        test_pulse = 1'b0; ready = 6'h3F; rec_ready = 1'b0; exp_ts = '0;
        #3;
        check("rst_pulse", 128'(trig_pulse), 128'd0);
        check("rst_le",    128'(trig_le),    128'd0);
        check("rst_id",    128'(trig_id),    128'd0);
        check("rst_ts",    128'(time_stamp), 128'd0);
        check("rst_rv",    128'(rec_valid),  128'd0);
        check("rst_skip",  128'(skip_cnt),   128'd0);
        check("rst_presc", 128'(presc_cnt),  128'd0);
        check("rst_lost",  128'(lost_cnt),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        check("ts_start", 128'(time_stamp), 128'd1);
        tick();
        check("ts_inc", 128'(time_stamp), 128'(exp_ts));

        // AND mode, LE spread exactly at the limit
        le_rel = {8'h50, 8'd9, 8'd7, 8'd5};
        valid  = 4'b0111;
        tick();
        check("and_early", 128'(trig_pulse), 128'd0);
        rec_ts = exp_ts;
        valid  = '0;
        tick();
        check("and_pulse", 128'(trig_pulse), 128'd1);
        check("and_le",    128'(trig_le),    128'd9);
        check("and_id",    128'(trig_id),    128'd1);
        tick();
        check("and_one_cyc", 128'(trig_pulse), 128'd0);
        check("and_rv",      128'(rec_valid),  128'd1);
        check("and_rec",     128'(rec_data),   128'({32'd0, rec_ts, 4'b0111}));

        // LE spread one over the limit
        do_start();
        le_rel = {8'h50, 8'd10, 8'd7, 8'd5};
        valid  = 4'b0111;
        tick();
        valid  = '0;
        tick();
        check("win_pulse", 128'(trig_pulse), 128'd0);
        tick();
        check("win_id",    128'(trig_id),   128'd0);
        check("win_skip",  128'(skip_cnt),  128'd0);
        check("win_presc", 128'(presc_cnt), 128'd0);
        check("win_lost",  128'(lost_cnt),  128'd0);
        check("win_rv",    128'(rec_valid), 128'd0);

        // OR mode with output ready masking
        conf_mode = 2'd1; ready = 6'b110111; conf_en_output = 6'b110111;
        valid = 4'b0001;
        tick();
        valid = '0;
        tick();
        check("or_masked_pulse", 128'(trig_pulse), 128'd1);
        tick();
        conf_en_output = 6'h3F;
        valid = 4'b0001;
        tick();
        valid = '0;
        tick();
        check("or_busy_pulse", 128'(trig_pulse), 128'd0);
        check("or_busy_skip",  128'(skip_cnt),   128'd1);
        check("or_busy_id",    128'(trig_id),    128'd1);
        ready = 6'h3F;
        tick();

        // Majority of 3 over four channels
        conf_mode = 2'd2; conf_en_input = 4'b1111; conf_min_hits = 5'd3;
        le_rel = {8'd2, 8'd1, 8'd3, 8'd1};
        valid = 4'b1011;
        tick();
        valid = '0;
        tick();
        check("maj_pulse", 128'(trig_pulse), 128'd1);
        check("maj_le",    128'(trig_le),    128'd3);
        check("maj_id",    128'(trig_id),    128'd2);
        tick();
        valid = 4'b0011;
        tick();
        valid = '0;
        tick();
        check("maj_low_pulse", 128'(trig_pulse), 128'd0);
        check("maj_low_id",    128'(trig_id),    128'd2);

        // Test-pulse-only mode
        conf_mode = 2'd3;
        valid = 4'b1111;
        tick();
        valid = '0;
        tick();
        check("tp_hits_ignored", 128'(trig_pulse), 128'd0);
        tick();
        cand_tp(saw);
        check("tp_fire", 128'(saw),     128'd1);
        check("tp_id",   128'(trig_id), 128'd3);

        // START coinciding with a candidate
        test_pulse = 1'b1;
        tick();
        test_pulse = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ts = 64'd1;
        check("start_cand_pulse", 128'(trig_pulse), 128'd0);
        check("start_cand_id",    128'(trig_id),    128'd0);
        check("start_cand_skip",  128'(skip_cnt),   128'd0);
        check("start_cand_rv",    128'(rec_valid),  128'd0);
        tick();

        // Prescale 1 of 3
        conf_prescale = 16'd2;
        npulse = 0;
        for (int k = 0; k < 9; k++) begin
            cand_tp(saw);
            npulse += int'(saw);
        end
        check("psc_pulses", 128'(npulse),    128'd3);
        check("psc_id",     128'(trig_id),   128'd3);
        check("psc_cnt",    128'(presc_cnt), 128'd6);
        rec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("psc_rv",     128'(rec_valid), 128'd1);
            check("psc_rec_id", 128'(rec_data[REC_W-1 -: 32]), 128'(k));
            tick();
        end
        rec_ready = 1'b0;
        check("psc_empty", 128'(rec_valid), 128'd0);

        // FIFO overflow, then push and pop together while full
        do_start();
        conf_prescale = 16'd0;
        for (int k = 0; k < 10; k++) cand_tp(saw);
        check("ovf_id",   128'(trig_id),   128'd10);
        check("ovf_lost", 128'(lost_cnt),  128'd2);
        check("ovf_rv",   128'(rec_valid), 128'd1);
        test_pulse = 1'b1;
        tick();
        test_pulse = 1'b0;
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("full_pp_pulse", 128'(trig_pulse), 128'd1);
        check("full_pp_lost",  128'(lost_cnt),   128'd2);
        check("full_pp_id",    128'(trig_id),    128'd11);
        tick();
        rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_id = (k < 7) ? 32'(k + 1) : 32'd10;
            check("ovf_rv_k",   128'(rec_valid), 128'd1);
            check("ovf_rec_id", 128'(rec_data[REC_W-1 -: 32]), 128'(exp_id));
            tick();
        end
        rec_ready = 1'b0;
        check("ovf_empty", 128'(rec_valid), 128'd0);

`ifdef TLU_TRIG_HOLDOFF_EN
        // Holdoff of 20 cycles with candidates every 10 cycles
        do_start();
        conf_holdoff = 16'd20;
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            test_pulse = 1'b1;
            tick();
            test_pulse = 1'b0;
            tick();
            npulse += int'(trig_pulse);
            repeat (8) tick();
        end
        check("hold_pulses", 128'(npulse),   128'd2);
        check("hold_skip",   128'(skip_cnt), 128'd4);
        conf_holdoff = 16'd0;
`endif

        // Asynchronous reset mid-operation
        cand_tp(saw);
        check("pre_rst_rv", 128'(rec_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rv", 128'(rec_valid),  128'd0);
        check("async_ts", 128'(time_stamp), 128'd0);
        check("async_id", 128'(trig_id),    128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tlu_trigger_logic.md
# tlu_trigger_logic

Parametrised coincidence and trigger-generation unit for the TLU master, single clock domain (CLK40).
- Combines per-channel hit validity and relative leading-edge times from N_IN input receivers into a trigger decision (AND, OR, majority or test-only mode), with leading-edge window check, output-ready masking and prescaling.
- Issues a one-cycle trigger to the N_OUT DUT transmitters and pushes a trigger record into an internal FIFO with a valid/ready read side.
- Generalises the fixed 4-in/6-out AND-only trigger logic of the current core.

## Interface
- N_IN, 4: number of beam-trigger input channels (1..16)
- N_OUT, 6: number of DUT outputs (1..16)
- LE_WIDTH, 8: width of relative leading-edge values
- TRIG_ID_WIDTH, 32: trigger ID counter width
- CNT_WIDTH, 16: width of saturating status counters
- REC_ASIZE, 3: record FIFO depth = 2**REC_ASIZE
- CLK40  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  synchronous one-cycle run start/clear
- CONF_MODE  in  2  0=AND, 1=OR, 2=majority, 3=test pulse only
- CONF_EN_INPUT  in  N_IN  channel enables
- CONF_MIN_HITS  in  5  majority threshold
- CONF_MAX_LE_DISTANCE  in  LE_WIDTH  max allowed (max LE − min LE)
- CONF_EN_OUTPUT  in  N_OUT  output enables
- CONF_PRESCALE  in  16  accept 1 of (CONF_PRESCALE+1) candidates
- VALID  in  N_IN  per-channel hit valid
- LE_REL  in  N_IN*LE_WIDTH  relative leading edges, channel 0 in LSBs
- TEST_PULSE  in  1  forces a coincidence condition
- READY  in  N_OUT  per-output ready from transmitters
- TRIG_PULSE  out  1  one-cycle accepted trigger
- TRIG_LE  out  LE_WIDTH  max LE of participating channels, valid with TRIG_PULSE
- TRIG_ID  out  TRIG_ID_WIDTH  ID of the next trigger
- TIME_STAMP  out  64  run time counter
- REC_VALID / REC_READY  out / in  1  record stream handshake
- REC_DATA  out  TRIG_ID_WIDTH+64+N_IN  {trig_id, time_stamp, hit_mask}
- SKIP_CNT, PRESC_CNT, LOST_CNT  out  CNT_WIDTH  busy-skipped, prescaled-away, and FIFO-dropped counts

## Operation
- Participating channels: P = VALID & CONF_EN_INPUT.
- Condition C (combinational):
  - AND: P == CONF_EN_INPUT and CONF_EN_INPUT != 0.
  - OR: P != 0.
  - Majority: popcount(P) >= CONF_MIN_HITS and CONF_MIN_HITS != 0.
  - In modes 0–2, C additionally requires (max LE − min LE over P) <= CONF_MAX_LE_DISTANCE.
  - Mode 3: C is 0.
  - In every mode, C is ORed with TEST_PULSE.
- Candidate: rising edge of registered C (c_q & !c_qq).
- Ready gate: all_ready = &(READY | ~CONF_EN_OUTPUT).
- Candidate with !all_ready: SKIP_CNT++; the prescaler is not advanced.
- Candidate with all_ready:
  - If prescale count == CONF_PRESCALE, accept and clear the count.
  - Otherwise, increment the count and PRESC_CNT++.
- Accept:
  - TRIG_PULSE=1, TRIG_LE latched, record {TRIG_ID, TIME_STAMP, P} pushed, TRIG_ID++ (wraps).
  - Record FIFO full: record dropped, LOST_CNT++, trigger still issued.
- TIME_STAMP: +1 per cycle, saturates at all ones. Set to 1 on START.
- Status counters saturate at all ones.
- START clears TRIG_ID, the status counters, the prescale count and the holdoff counter, and flushes the FIFO.
- START in the same cycle as a candidate: START wins and the candidate is neither issued nor counted.
- REC_DATA is valid whenever REC_VALID=1. A pop happens on REC_VALID & REC_READY.

## Timing
- Reset values: every output is 0, except REC_VALID=0 and TIME_STAMP=0. FIFO is empty.
- TRIG_PULSE is high exactly 2 cycles after the first cycle C=1; TRIG_LE, TRIG_ID++ and the push happen on the same edge.
- C must return to 0 for at least one cycle before the next candidate.
- Record appears on REC_VALID 1 cycle after the push when the FIFO was empty.
- Push and pop in the same cycle while full: pop frees a slot, push succeeds, LOST_CNT unchanged.
- Reset mid-operation clears the FIFO and counters immediately (asynchronous).

## Configuration
- TLU_TRIG_HOLDOFF_EN defined:
  - Adds input CONF_HOLDOFF[15:0].
  - After each accept, candidates arriving within CONF_HOLDOFF cycles are rejected and counted in SKIP_CNT.
  - CONF_HOLDOFF=0 disables the holdoff.
- Not defined: port absent; no holdoff logic.

## Test plan
- AND mode, CONF_EN_INPUT=4'b0111, VALID 0111, LE_REL 5/7/9, CONF_MAX_LE_DISTANCE=4 -> one TRIG_PULSE 2 cycles later, TRIG_LE=9, REC_DATA hit mask 0111, TRIG_ID 0 in record.
- Same stimulus with LE 5/7/10 -> no trigger, all counters 0.
- OR mode, READY bit 3 low with CONF_EN_OUTPUT bit 3 =0 -> trigger issued; with enable bit 3 =1 -> SKIP_CNT=1, no pulse.
- CONF_PRESCALE=2, 9 candidates -> 3 triggers (IDs 0,1,2), PRESC_CNT=6.
- REC_READY held low, REC_ASIZE=3, 10 triggers -> TRIG_ID=10, LOST_CNT=2, 8 records then read out in order with IDs 0..7.
- TLU_TRIG_HOLDOFF_EN, CONF_HOLDOFF=20, candidates 10 cycles apart -> only every third candidate accepted, SKIP_CNT counts the rest.
